// File: rtl/reg_slice_2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_slice_2d_pkg
// Description : Shared constants and types for the two-entry register slice.
// Revision    : 1.0  initial release
// ============================================================================
package reg_slice_2d_pkg;

  // Occupancy counter width: holds 0..2 entries.
  localparam int unsigned c_COUNT_W = 2;

  // Occupancy value type as seen on the count port.
  typedef logic [c_COUNT_W-1:0] count_t;

endpackage : reg_slice_2d_pkg
`default_nettype wire

// File: rtl/reg_slice_2d.sv
`default_nettype none
// ============================================================================
// Module      : reg_slice_2d
// Description : Fully registered two-entry valid/ready slice (skid buffer).
//               All outputs decode from registers only, so no combinational
//               path crosses the slice in either direction.
// Revision    : 1.0  initial release
// ============================================================================
module reg_slice_2d
  import reg_slice_2d_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  output logic [WIDTH-1:0]     b_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [c_COUNT_W-1:0] count
);

  // Encoding equals the number of held entries, so count is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_drain;
  logic             w_ld_main_a;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  assign a_ready  = (r_state != ST_FULL);
  assign b_valid  = (r_state != ST_EMPTY);
  assign b_data   = r_main;
  assign count    = count_t'(r_state);

  assign w_accept = a_valid && a_ready;
  assign w_drain  = b_valid && b_ready;

  // State register; flush is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and data-load decode. Flush drops everything, including any
  // word offered in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_a    = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_ld_main_a = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_ld_main_a = 1'b1;
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Payload registers carry no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_ld_main_a) begin
      r_main <= a_data;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
    if (w_ld_skid) begin
      r_skid <= a_data;
    end
  end

  // A stalled output word must not change until it is taken.
  a_b_data_stable : assert property (@(posedge clk) disable iff (rst)
    (b_valid && !b_ready && !flush) |=> (b_valid && $stable(b_data)));

  // The unused encoding 3 must never be reached.
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    (r_state != 2'd3));

  // A full slice never takes a word.
  a_no_accept_full : assert property (@(posedge clk) disable iff (rst)
    !((r_state == ST_FULL) && w_accept));

endmodule : reg_slice_2d
`default_nettype wire

// File: tb/tb_reg_slice_2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_slice_2d
// Description : Self-checking bench for reg_slice_2d with a queue scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_slice_2d;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [1:0]       count;

  int               n_cmp;
  int               n_bad;

  // Scoreboard of words expected on b_data, oldest first.
  logic [WIDTH-1:0] q[$];

  // Result of the most recent clock step.
  logic             d_fire;
  logic             d_empty_pop;
  logic [WIDTH-1:0] d_got;
  logic [WIDTH-1:0] d_exp;

  reg_slice_2d #(.WIDTH(WIDTH)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge. Acceptance and drain are decided from the model's
  // occupancy, not from the DUT handshake outputs.
  task automatic tick();
    bit acc;
    bit drn;
    acc         = a_valid && (q.size() < 2);
    drn         = b_ready && (q.size() > 0);
    d_fire      = drn;
    d_got       = b_data;
    d_exp       = '0;
    d_empty_pop = 1'b0;
    if (drn) d_exp = q.pop_front();
    if (rst || flush) q.delete();
    else if (acc) q.push_back(a_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; a_valid = 1'b0; a_data = '0; b_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    q.delete();
    n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got=%0b exp=0", b_valid); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_ready got=%0b exp=1", a_ready); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] exp_w;
    b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1;
      a_data  = WIDTH'(64'h10 + i);
      tick();
      exp_w = WIDTH'(64'h10 + i);
      n_cmp++; if (b_data !== exp_w) begin n_bad++; $display("FAIL stream_b_data i=%0d got=%h exp=%h", i, b_data, exp_w); end
      n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count); end
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL stream_a_ready i=%0d got=%0b exp=1", i, a_ready); end
      if (i > 0) begin
        n_cmp++; if (!d_fire || d_got !== d_exp) begin n_bad++; $display("FAIL stream_drain i=%0d got=%h exp=%h", i, d_got, d_exp); end
      end
    end
    a_valid = 1'b0;
    tick();
    n_cmp++; if (d_got !== 64'h17) begin n_bad++; $display("FAIL stream_last got=%h exp=17", d_got); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL stream_empty got=%0d exp=0", count); end
  endtask

  task automatic test_backpressure();
    b_ready = 1'b0;
    a_valid = 1'b1; a_data = 64'hA;
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL bp_count1 got=%0d exp=1", count); end
    a_data = 64'hB;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL bp_count2 got=%0d exp=2", count); end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL bp_a_ready got=%0b exp=0", a_ready); end
    a_data = 64'hC;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL bp_no_take got=%0d exp=2", count); end
    n_cmp++; if (b_data !== 64'hA) begin n_bad++; $display("FAIL bp_hold got=%h exp=a", b_data); end
  endtask

  task automatic test_drain_full();
    b_ready = 1'b1;
    tick();
    n_cmp++; if (d_got !== 64'hA) begin n_bad++; $display("FAIL df_first got=%h exp=a", d_got); end
    n_cmp++; if (b_data !== 64'hB) begin n_bad++; $display("FAIL df_b_data got=%h exp=b", b_data); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL df_a_ready got=%0b exp=1", a_ready); end
    b_ready = 1'b0;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL df_take_c got=%0d exp=2", count); end
    a_valid = 1'b0; b_ready = 1'b1;
    tick();
    n_cmp++; if (d_got !== 64'hB) begin n_bad++; $display("FAIL df_second got=%h exp=b", d_got); end
    tick();
    n_cmp++; if (d_got !== 64'hC) begin n_bad++; $display("FAIL df_third got=%h exp=c", d_got); end
    n_cmp++; if (q.size() != 0 || count !== 2'd0) begin n_bad++; $display("FAIL df_empty got=%0d exp=0", count); end
  endtask

  task automatic test_simul();
    b_ready = 1'b0; a_valid = 1'b1; a_data = 64'h1;
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL sim_load got=%0d exp=1", count); end
    a_data = 64'h2; b_ready = 1'b1;
    tick();
    n_cmp++; if (d_got !== 64'h1) begin n_bad++; $display("FAIL sim_drain got=%h exp=1", d_got); end
    n_cmp++; if (b_data !== 64'h2) begin n_bad++; $display("FAIL sim_b_data got=%h exp=2", b_data); end
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL sim_count got=%0d exp=1", count); end
    a_valid = 1'b0;
    tick();
    n_cmp++; if (d_got !== 64'h2) begin n_bad++; $display("FAIL sim_last got=%h exp=2", d_got); end
  endtask

  task automatic test_flush();
    b_ready = 1'b0; a_valid = 1'b1; a_data = 64'h5;
    tick();
    a_data = 64'h6;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL fl_full got=%0d exp=2", count); end
    flush = 1'b1; a_data = 64'h7;
    tick();
    flush = 1'b0;
    n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL fl_b_valid got=%0b exp=0", b_valid); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL fl_count got=%0d exp=0", count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL fl_a_ready got=%0b exp=1", a_ready); end
    a_data = 64'h8;
    tick();
    a_valid = 1'b0; b_ready = 1'b1;
    n_cmp++; if (b_data !== 64'h8) begin n_bad++; $display("FAIL fl_after got=%h exp=8", b_data); end
    tick();
    n_cmp++; if (d_got !== 64'h8) begin n_bad++; $display("FAIL fl_drain got=%h exp=8", d_got); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL fl_end got=%0d exp=0", count); end
  endtask

  task automatic test_rst_mid();
    b_ready = 1'b0; a_valid = 1'b1; a_data = 64'h33;
    tick();
    a_data = 64'h44;
    tick();
    rst = 1'b1; a_valid = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (count !== 2'd0 || b_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid got=%0d/%0b exp=0/0", count, b_valid); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_a_ready got=%0b exp=1", a_ready); end
  endtask

  task automatic test_soak();
    int bad0;
    bad0 = n_bad;
    for (int c = 0; c < 10000; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_data  = {$urandom(), $urandom()};
      b_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      tick();
      if (d_fire) begin
        n_cmp++; if (d_got !== d_exp) begin n_bad++; if (n_bad - bad0 < 10) $display("FAIL soak_data cyc=%0d got=%h exp=%h", c, d_got, d_exp); end
      end
      n_cmp++; if (count !== 2'(q.size())) begin n_bad++; if (n_bad - bad0 < 10) $display("FAIL soak_count cyc=%0d got=%0d exp=%0d", c, count, q.size()); end
      n_cmp++; if (b_valid !== (q.size() != 0)) begin n_bad++; if (n_bad - bad0 < 10) $display("FAIL soak_b_valid cyc=%0d got=%0b", c, b_valid); end
      n_cmp++; if (a_ready !== (q.size() != 2)) begin n_bad++; if (n_bad - bad0 < 10) $display("FAIL soak_a_ready cyc=%0d got=%0b", c, a_ready); end
    end
    flush = 1'b0; a_valid = 1'b0; b_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain_full();
    test_simul();
    test_flush();
    test_rst_mid();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_slice_2d
`default_nettype wire
